// File: rtl/seven_segment_pkg.sv
// seven_segment_pkg: glyph table, capture FSM states and select-to-index map shared by the 7-segment bus blocks
package seven_segment_pkg;

    localparam logic [6:0] GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    localparam logic [3:0] SEL_OF_IDX [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    typedef enum logic [1:0] {WAIT_SEL, SETTLE, HOLD} state_e;

    function automatic logic [1:0] sel_to_idx(input logic [3:0] sel);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) if (sel == SEL_OF_IDX[i]) idx = 2'(i);
        return idx;
    endfunction

endpackage

// File: rtl/seven_segment_glyph_decode.sv
// seven_segment_glyph_decode: active-low g..a pattern back to a hex nibble, valid low for unknown glyphs
module seven_segment_glyph_decode
    import seven_segment_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic       valid_o,
    output logic [3:0] nibble_o
);

    always_comb begin
        valid_o  = 1'b0;
        nibble_o = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (seg_i == GLYPH[i]) begin
                valid_o  = 1'b1;
                nibble_o = 4'(i);
            end
        end
    end

endmodule

// File: rtl/seven_segment_capture.sv
// seven_segment_capture: rebuilds a 16-bit value from a multiplexed active-low 7-segment bus
// Optional SEVSEG_CAPTURE_DP_EN adds o_Dp, the per-digit decimal points latched with o_Data.
module seven_segment_capture
    import seven_segment_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [3:0]  i_Chosen_Segment,
    input  logic [7:0]  i_SevenSegmentDisplay,
    output logic [15:0] o_Data,
    output logic        o_Valid,
    output logic        o_Error,
    output logic [3:0]  o_Captured
`ifdef SEVSEG_CAPTURE_DP_EN
    ,
    output logic [3:0]  o_Dp
`endif
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);

    logic [11:0]   sync_q [SYNC_STAGES];
    logic [11:0]   prev_q, p;
    logic [3:0]    sel;
    logic [CW-1:0] cnt_q, cnt_d;
    state_e        state_q, state_d;
    logic          changed, onehot, stable, capture, glyph_ok;
    logic [3:0]    nibble, mask_q, mask_d, mask_base;
    logic [1:0]    idx;
    logic [15:0]   shadow_q, shadow_d, data_q;
    logic          valid_q, err_pend_q, err_pend_d, error_q;

    assign p       = sync_q[SYNC_STAGES-1];
    assign sel     = p[11:8];
    assign idx     = sel_to_idx(sel);
    assign changed = p != prev_q;
    assign onehot  = $onehot(~sel);
    assign cnt_d   = changed ? CW'(1) : (cnt_q == CW'(STABLE_CYCLES) ? cnt_q : cnt_q + CW'(1));
    assign stable  = cnt_d == CW'(STABLE_CYCLES);

    seven_segment_glyph_decode u_decode (
        .seg_i    (p[6:0]),
        .valid_o  (glyph_ok),
        .nibble_o (nibble)
    );

    // A fresh pair that is already stable enough is captured in the same cycle, so a one-clock scan is never missed.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        if (changed) begin
            state_d = !onehot ? WAIT_SEL : (stable ? HOLD : SETTLE);
            capture = onehot && stable;
        end else if (state_q == SETTLE && stable) begin
            state_d = HOLD;
            capture = 1'b1;
        end
    end

    // A full mask is being flushed to o_Data this edge, so a new frame starts from an empty mask.
    always_comb begin
        mask_base  = &mask_q ? 4'b0000 : mask_q;
        mask_d     = mask_base;
        shadow_d   = shadow_q;
        err_pend_d = 1'b0;
        if (capture && glyph_ok) begin
            mask_d                = mask_base | (4'b0001 << idx);
            shadow_d[4*idx +: 4] = nibble;
        end else if (capture) begin
            mask_d     = 4'b0000;
            shadow_d   = 16'h0000;
            err_pend_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= WAIT_SEL;
        else          state_q <= state_d;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '1;
            prev_q     <= '1;
            cnt_q      <= '0;
            mask_q     <= '0;
            shadow_q   <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            err_pend_q <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            sync_q[0] <= {i_Chosen_Segment, i_SevenSegmentDisplay};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev_q     <= p;
            cnt_q      <= cnt_d;
            mask_q     <= mask_d;
            shadow_q   <= shadow_d;
            data_q     <= &mask_q ? shadow_q : data_q;
            valid_q    <= &mask_q;
            err_pend_q <= err_pend_d;
            error_q    <= err_pend_q;
        end
    end

    assign o_Data     = data_q;
    assign o_Valid    = valid_q;
    assign o_Error    = error_q;
    assign o_Captured = mask_q;

`ifdef SEVSEG_CAPTURE_DP_EN
    logic [3:0] dps_q, dps_d, dp_q;

    always_comb begin
        dps_d = dps_q;
        if (capture && glyph_ok) dps_d[idx] = ~p[7];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            dps_q <= '0;
            dp_q  <= '0;
        end else begin
            dps_q <= dps_d;
            dp_q  <= &mask_q ? dps_q : dp_q;
        end
    end

    assign o_Dp = dp_q;
`endif

endmodule

// File: tb/tb_seven_segment_capture.sv
// tb_seven_segment_capture: table-driven scans with a scoreboard of expected frames and errors
module tb_seven_segment_capture;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  sel_a = 4'hF, sel_b = 4'hF;
    logic [7:0]  seg_a = 8'hFF, seg_b = 8'hFF;
    logic [15:0] data_a, data_b;
    logic        valid_a, valid_b, err_a, err_b;
    logic [3:0]  cap_a, cap_b;
`ifdef SEVSEG_CAPTURE_DP_EN
    logic [3:0]  dp_a, dp_b;
`endif

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    seven_segment_capture #(.SYNC_STAGES(2), .STABLE_CYCLES(1)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_Chosen_Segment(sel_a), .i_SevenSegmentDisplay(seg_a),
        .o_Data(data_a), .o_Valid(valid_a), .o_Error(err_a), .o_Captured(cap_a)
`ifdef SEVSEG_CAPTURE_DP_EN
        , .o_Dp(dp_a)
`endif
    );

    seven_segment_capture #(.SYNC_STAGES(2), .STABLE_CYCLES(3)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_Chosen_Segment(sel_b), .i_SevenSegmentDisplay(seg_b),
        .o_Data(data_b), .o_Valid(valid_b), .o_Error(err_b), .o_Captured(cap_b)
`ifdef SEVSEG_CAPTURE_DP_EN
        , .o_Dp(dp_b)
`endif
    );

    logic [6:0] glyph [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef struct { logic err; logic [15:0] data; } exp_t;
    typedef struct { logic [15:0] val; int bad; logic [15:0] exp; } vec_t;

    exp_t qa[$], qb[$];
    exp_t ea, eb;
    vec_t vecs [7];
    int checks = 0, passed = 0;
    int last_valid_a = 0, last_valid_b = 0, last_drive_a = 0, last_drive_b = 0;
    logic [15:0] last_good;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (valid_a || err_a) begin
            chk("A valid/error exclusive", {31'b0, valid_a & err_a}, 0);
            if (qa.size() == 0) chk("A unexpected pulse", {30'b0, valid_a, err_a}, 0);
            else begin
                ea = qa.pop_front();
                chk("A pulse kind error", {31'b0, err_a}, {31'b0, ea.err});
                if (!ea.err) chk("A data", {16'b0, data_a}, {16'b0, ea.data});
                if (valid_a) last_valid_a = cyc;
            end
        end
        if (valid_b || err_b) begin
            chk("B valid/error exclusive", {31'b0, valid_b & err_b}, 0);
            if (qb.size() == 0) chk("B unexpected pulse", {30'b0, valid_b, err_b}, 0);
            else begin
                eb = qb.pop_front();
                chk("B pulse kind error", {31'b0, err_b}, {31'b0, eb.err});
                if (!eb.err) chk("B data", {16'b0, data_b}, {16'b0, eb.data});
                if (valid_b) last_valid_b = cyc;
            end
        end
    end

    task automatic drive_a(input logic [3:0] s, input logic [7:0] g);
        @(posedge clk);
        #1;
        sel_a = s;
        seg_a = g;
    endtask

    task automatic drive_b(input logic [3:0] s, input logic [7:0] g, input int n);
        @(posedge clk);
        #1;
        sel_b = s;
        seg_b = g;
        last_drive_b = cyc;
        repeat (n - 1) @(posedge clk);
    endtask

    task automatic scan_a(input logic [15:0] v, input int upto, input int bad, input int dpk);
        for (int k = 0; k <= upto; k++) begin
            drive_a(~(4'b0001 << k), {(k == dpk) ? 1'b0 : 1'b1, (k == bad) ? 7'h7F : glyph[v[4*k +: 4]]});
            last_drive_a = cyc;
        end
        drive_a(4'hF, 8'hFF);
    endtask

    initial begin
        vecs[0] = '{16'hA5C3, -1, 16'hA5C3};
        vecs[1] = '{16'h0123, -1, 16'h0123};
        vecs[2] = '{16'h4567, -1, 16'h4567};
        vecs[3] = '{16'h89AB, -1, 16'h89AB};
        vecs[4] = '{16'hCDEF, -1, 16'hCDEF};
        vecs[5] = '{16'h1234,  1, 16'h0000};
        vecs[6] = '{16'hFFFF, -1, 16'hFFFF};
        last_good = 16'h0000;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("idle data", {16'b0, data_a}, 0);
        chk("idle captured", {28'b0, cap_a}, 0);
        chk("idle valid", {31'b0, valid_a}, 0);
        chk("idle error", {31'b0, err_a}, 0);

        for (int r = 0; r < 7; r++) begin
            if (vecs[r].bad >= 0) qa.push_back('{1'b1, 16'h0000});
            else qa.push_back('{1'b0, vecs[r].exp});
            scan_a(vecs[r].val, vecs[r].bad >= 0 ? vecs[r].bad : 3, vecs[r].bad, -1);
            repeat (8) @(posedge clk);
            @(negedge clk);
            chk("A row drained", qa.size(), 0);
            chk("A captured cleared", {28'b0, cap_a}, 0);
            if (vecs[r].bad >= 0) chk("A data kept after error", {16'b0, data_a}, {16'b0, last_good});
            else last_good = vecs[r].exp;
            if (r == 0) chk("A latency", last_valid_a - last_drive_a, 4);
        end

        qa.push_back('{1'b0, 16'h9876});
        drive_a(4'b1110, {1'b1, glyph[6]});
        repeat (5) drive_a(4'b1100, 8'hFF);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("two-select captured", {28'b0, cap_a}, 4'b0001);
        drive_a(4'b1101, {1'b1, glyph[7]});
        drive_a(4'b1011, {1'b1, glyph[8]});
        drive_a(4'b0111, {1'b1, glyph[9]});
        drive_a(4'hF, 8'hFF);
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("two-select drained", qa.size(), 0);

        qb.push_back('{1'b0, 16'h1234});
        drive_b(4'b0111, {1'b1, glyph[1]}, 3);
        drive_b(4'b1011, 8'hFF, 1);
        drive_b(4'b1011, {1'b1, glyph[2]}, 3);
        drive_b(4'b1101, {1'b1, glyph[3]}, 3);
        drive_b(4'b1110, {1'b1, glyph[4]}, 3);
        drive_b(4'hF, 8'hFF, 1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("B drained", qb.size(), 0);
        chk("B captured cleared", {28'b0, cap_b}, 0);
        chk("B latency", last_valid_b - (last_drive_b - 3), 6);
        drive_b(4'b1110, {1'b1, glyph[5]}, 2);
        drive_b(4'hF, 8'hFF, 1);
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("B short hold ignored", {28'b0, cap_b}, 0);

`ifdef SEVSEG_CAPTURE_DP_EN
        qa.push_back('{1'b0, 16'h8888});
        scan_a(16'h8888, 3, -1, 2);
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("dp drained", qa.size(), 0);
        chk("dp value", {28'b0, dp_a}, 4'b0100);
`endif

        scan_a(16'h0321, 2, -1, -1);
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("partial captured", {28'b0, cap_a}, 4'b0111);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset captured", {28'b0, cap_a}, 0);
        chk("async reset data", {16'b0, data_a}, 0);
`ifdef SEVSEG_CAPTURE_DP_EN
        chk("async reset dp", {28'b0, dp_a}, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        drive_a(4'b0111, {1'b1, glyph[4]});
        drive_a(4'hF, 8'hFF);
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("post-reset captured", {28'b0, cap_a}, 4'b1000);
        chk("post-reset data", {16'b0, data_a}, 0);
        chk("final A queue", qa.size(), 0);
        chk("final B queue", qb.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
